// File: rtl/vga_sync_gen.sv
// VGA sync generator: registered row/col counts with zero-skew Hsync/Vsync,
// active flag and start strobes; stops only at a frame boundary once en_i drops.
module vga_sync_gen #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       Hsync_o,
    output logic       Vsync_o,
    output logic [9:0] col_count_o,
    output logic [9:0] row_count_o,
    output logic       active_o,
    output logic       frame_start_o,
    output logic       line_start_o,
    output logic       busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [9:0] LAST_COL = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] LAST_ROW = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);

    state_t     state_q;
    state_t     state_d;
    logic [9:0] col_d;
    logic [9:0] row_d;
    logic       running_d;
    logic       last_col;
    logic       last_pixel;

    // Everything is decoded from the next-state counts so the registered
    // syncs and strobes line up with the registered counts.
    always_comb begin
        state_d    = state_q;
        col_d      = '0;
        row_d      = '0;
        last_col   = (col_count_o == LAST_COL);
        last_pixel = last_col && (row_count_o == LAST_ROW);
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = RUN;
                end
            end
            RUN, DRAIN: begin
                col_d = last_col ? 10'd0 : col_count_o + 10'd1;
                if (last_col) begin
                    row_d = (row_count_o == LAST_ROW) ? 10'd0 : row_count_o + 10'd1;
                end else begin
                    row_d = row_count_o;
                end
                if (state_q == DRAIN && last_pixel && !en_i) begin
                    state_d = IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end else begin
                    state_d = en_i ? RUN : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            col_count_o   <= '0;
            row_count_o   <= '0;
            Hsync_o       <= 1'b0;
            Vsync_o       <= 1'b0;
            active_o      <= 1'b0;
            frame_start_o <= 1'b0;
            line_start_o  <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_count_o   <= col_d;
            row_count_o   <= row_d;
            Hsync_o       <= running_d && (col_d < ACT_COLS);
            Vsync_o       <= running_d && (row_d < ACT_ROWS);
            active_o      <= running_d && (col_d < ACT_COLS) && (row_d < ACT_ROWS);
            frame_start_o <= running_d && (col_d == 10'd0) && (row_d == 10'd0);
            line_start_o  <= running_d && (col_d == 10'd0);
            busy_o        <= running_d;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a pixel-index model predicts every output,
// and a behavioural sync-counting receiver checks the loopback counts.
module tb_vga_sync_gen;

    localparam int TC = 10;
    localparam int TR = 6;
    localparam int AC = 8;
    localparam int AR = 4;
    localparam int FRAME = TC * TR;

    logic       clk = 1'b0;
    logic       rstSig = 1'b1;
    logic       enSig = 1'b0;
    logic       Hsync_o, Vsync_o, active_o, frame_start_o, line_start_o, busy_o;
    logic [9:0] col_count_o, row_count_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        int col;
        int row;
        bit hs;
        bit vs;
        bit act;
        bit fs;
        bit ls;
        bit busy;
    } exp_t;

    exp_t expQ[$];

    // Model: a running flag plus a linear pixel index within the frame.
    bit mRunning = 1'b0;
    int mPix = 0;
    bit mEnPrev = 1'b0;

    // Receiver state for loopback.
    int rxCol = 0;
    int rxRow = 0;
    bit rxLocked = 1'b0;
    bit lastHs = 1'b0;
    bit lastVs = 1'b0;

    vga_sync_gen #(
        .TOTAL_COLS (TC),
        .TOTAL_ROWS (TR),
        .ACTIVE_COLS(AC),
        .ACTIVE_ROWS(AR)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rstSig),
        .en_i         (enSig),
        .Hsync_o      (Hsync_o),
        .Vsync_o      (Vsync_o),
        .col_count_o  (col_count_o),
        .row_count_o  (row_count_o),
        .active_o     (active_o),
        .frame_start_o(frame_start_o),
        .line_start_o (line_start_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, act, expv, $time);
        end
    endtask

    // A stop only happens at the last pixel when en was low on both the
    // previous and the current sample; otherwise frames run to completion.
    task automatic modelStep(input bit en, input bit rst);
        if (rst) begin
            mRunning = 1'b0;
            mPix     = 0;
        end else if (!mRunning) begin
            if (en) begin
                mRunning = 1'b1;
                mPix     = 0;
            end
        end else if (mPix == FRAME - 1 && !mEnPrev && !en) begin
            mRunning = 1'b0;
            mPix     = 0;
        end else begin
            mPix = (mPix + 1) % FRAME;
        end
        mEnPrev = en;
    endtask

    task automatic applyStimulus(input bit en, input bit rst);
        exp_t e;
        @(negedge clk);
        enSig  = en;
        rstSig = rst;
        modelStep(en, rst);
        e.col  = mRunning ? mPix % TC : 0;
        e.row  = mRunning ? mPix / TC : 0;
        e.hs   = mRunning && (e.col < AC);
        e.vs   = mRunning && (e.row < AR);
        e.act  = e.hs && e.vs;
        e.fs   = mRunning && (mPix == 0);
        e.ls   = mRunning && (e.col == 0);
        e.busy = mRunning;
        expQ.push_back(e);
    endtask

    task automatic runTo(input int pix, input bit en);
        int guard = 0;
        while (!(mRunning && mPix == pix) && guard < 200) begin
            applyStimulus(en, 1'b0);
            guard++;
        end
        checkOutput("runTo_reached", int'(guard < 200), 1);
    endtask

    // Monitor: every cycle the DUT presents a new output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("col", int'(col_count_o), e.col);
                checkOutput("row", int'(row_count_o), e.row);
                checkOutput("hsync", int'(Hsync_o), int'(e.hs));
                checkOutput("vsync", int'(Vsync_o), int'(e.vs));
                checkOutput("active", int'(active_o), int'(e.act));
                checkOutput("frame_start", int'(frame_start_o), int'(e.fs));
                checkOutput("line_start", int'(line_start_o), int'(e.ls));
                checkOutput("busy", int'(busy_o), int'(e.busy));

                if (Vsync_o && !lastVs) begin
                    rxCol    = 0;
                    rxRow    = 0;
                    rxLocked = 1'b1;
                end else if (Hsync_o && !lastHs) begin
                    rxCol = 0;
                    rxRow++;
                end else begin
                    rxCol++;
                end
                if (!e.busy) rxLocked = 1'b0;
                if (rxLocked) begin
                    checkOutput("loop_col", rxCol, e.col);
                    checkOutput("loop_row", rxRow, e.row);
                end
                lastHs = Hsync_o;
                lastVs = Vsync_o;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit en = 1'b1;
        bit rst;

        $display("[TB] reset then continuous run");
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        repeat (2 * FRAME + 5) applyStimulus(1'b1, 1'b0);

        $display("[TB] drop enable mid-frame, expect drain to frame end");
        runTo(25, 1'b1);
        repeat (45) applyStimulus(1'b0, 1'b0);

        $display("[TB] enable gap inside a frame");
        applyStimulus(1'b1, 1'b0);
        runTo(10, 1'b1);
        runTo(30, 1'b0);
        repeat (130) applyStimulus(1'b1, 1'b0);

        $display("[TB] reset mid-frame with enable held");
        runTo(34, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b1, 1'b0);

        $display("[TB] randomized enable and reset");
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(en, rst);
        end
        repeat (70) applyStimulus(1'b0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates the internal VGA sync format consumed by the team's sync-counting receiver.
- Hsync is high during the active columns of every line and low for the rest of the line.
- Vsync is high during the active rows and low for the rest of the frame.
- The rising edge of Vsync marks row 0, col 0.
- Sits at the head of the video pipeline. Provides frame-aligned start/stop control plus registered row/col counts, an active-video flag and start strobes.

Parameters:
- TOTAL_COLS, 800, pixel clocks per line; must be 2..1024.
- TOTAL_ROWS, 525, lines per frame; must be 2..1024.
- ACTIVE_COLS, 640, columns with Hsync high; must be 1..TOTAL_COLS-1.
- ACTIVE_ROWS, 480, rows with Vsync high; must be 1..TOTAL_ROWS-1.

Ports:
- clk_i  input  1  pixel clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  run request; sampled every cycle.
- Hsync_o  output  1  high while col_count_o < ACTIVE_COLS and the generator is running.
- Vsync_o  output  1  high while row_count_o < ACTIVE_ROWS and the generator is running.
- col_count_o  output  10  current column.
- row_count_o  output  10  current row.
- active_o  output  1  Hsync_o & Vsync_o.
- frame_start_o  output  1  one-cycle strobe at row 0, col 0.
- line_start_o  output  1  one-cycle strobe at col 0 of every row.
- busy_o  output  1  high in RUN or DRAIN.

Behaviour:
- Reset (rst_i=1 at a clock edge): next cycle every output is 0 and the state is IDLE. Reset has priority over en_i and over any mid-frame position.
- All outputs are registered. Syncs, strobes and active_o are decoded from the next-state counts, so they align exactly with col_count_o/row_count_o in the same cycle (zero skew).
- States:
  - IDLE: counts held at 0; Hsync_o=Vsync_o=active_o=0; strobes 0; busy_o=0.
  - IDLE -> RUN when en_i=1. First RUN cycle (one cycle after en_i is sampled): col=0, row=0, Hsync_o=Vsync_o=1, frame_start_o=1, line_start_o=1. This gives the receiver its Vsync rising edge.
  - RUN: col increments each cycle.
    - At col=TOTAL_COLS-1: col wraps to 0 and row increments.
    - At row=TOTAL_ROWS-1 and col=TOTAL_COLS-1: row wraps to 0 and a new frame starts.
  - RUN -> DRAIN when en_i=0. Counting continues unchanged.
  - DRAIN -> RUN when en_i=1 before frame end. No disturbance to counts or syncs.
  - DRAIN at the last pixel (row=TOTAL_ROWS-1, col=TOTAL_COLS-1) with en_i=0 -> IDLE. Next cycle: counts 0, syncs 0, no frame_start_o.
  - DRAIN at the last pixel with en_i=1 -> RUN, wrapping normally with frame_start_o=1.
- Frames are never truncated by en_i; only rst_i aborts a frame.
- Sync decode while running:
  - Hsync_o = (col < ACTIVE_COLS).
  - Vsync_o = (row < ACTIVE_ROWS).
  - Vsync_o does not depend on col, so it changes on the col=0 cycle of rows 0 and ACTIVE_ROWS.
- Strobes:
  - frame_start_o = running & row==0 & col==0.
  - line_start_o = running & col==0.
  - Exactly one frame_start_o per TOTAL_COLS*TOTAL_ROWS cycles in continuous RUN.
- Widths: counts are 10 bits unsigned; no overflow is possible within legal parameters. Comparisons are unsigned.
- Loopback: feeding Hsync_o/Vsync_o to the team's sync-counting receiver must make its counts equal this block's counts delayed by exactly one cycle.

Test Plan:
Small parameters for all scenarios: TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE_COLS=8, ACTIVE_ROWS=4; frame = 60 cycles.
1. rst_i=1 two cycles, then 0 with en_i=1 from cycle 3 -> cycle 4: frame_start_o=1, line_start_o=1, col=0, row=0, Hsync_o=Vsync_o=1, busy_o=1. Every output was 0 before cycle 4.
2. Continuous RUN ->
   - Hsync_o falls at col=8 and rises at col=0.
   - row increments on the col 9->0 wrap.
   - Vsync_o falls at row=4, col=0 and rises at row=0, col=0.
   - active_o is high for 32 cycles per frame.
   - frame_start_o is spaced exactly 60 cycles apart.
3. en_i=0 at row=2, col=5 -> counting continues through row=5, col=9. The next cycle shows counts 0, Hsync_o=Vsync_o=0, busy_o=0, and no frame_start_o.
4. en_i=0 at row=1, then en_i=1 at row=3 -> no gap; frame_start_o stays at 60-cycle spacing; busy_o stays 1 throughout.
5. rst_i=1 for one cycle at row=3, col=4 with en_i held high -> next cycle IDLE with all outputs 0. The following cycle is RUN at row 0, col 0 with frame_start_o=1.
6. Loopback: Hsync_o/Vsync_o drive the sync-counting receiver over 3 frames -> receiver counts equal the generator counts one cycle later on every cycle from the first frame_start onward.
